// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALU control codes, ALUOp classes and R-type funct values.
package alu_pkg;

  // ALU control codes presented to the ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // ALUOp classes from the main decoder; 2'b11 is not assigned
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-ALU stage bus: upstream handshake and operands, downstream handshake and
// registered ALU inputs. The stage is the slave; its driver/consumer side is the master.
interface id_ex_stage_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned IMMW = 16,
  parameter int unsigned RW   = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_alu_op;
  logic [5:0]      in_funct;
  logic            in_alu_src;
  logic [DW-1:0]   in_rs_data;
  logic [DW-1:0]   in_rt_data;
  logic [IMMW-1:0] in_imm;
  logic [RW-1:0]   in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      ALUControl;
  logic [DW-1:0]   DataIn0;
  logic [DW-1:0]   DataIn1;
  logic [RW-1:0]   out_rd;
  logic            out_illegal;
  logic [31:0]     issue_count;

  modport slave (
    input  flush, in_valid, in_alu_op, in_funct, in_alu_src, in_rs_data, in_rt_data,
           in_imm, in_rd, out_ready,
    output in_ready, out_valid, ALUControl, DataIn0, DataIn1, out_rd, out_illegal,
           issue_count
  );

  modport master (
    output flush, in_valid, in_alu_op, in_funct, in_alu_src, in_rs_data, in_rt_data,
           in_imm, in_rd, out_ready,
    input  in_ready, out_valid, ALUControl, DataIn0, DataIn1, out_rd, out_illegal,
           issue_count
  );
endinterface

// File: rtl/alu_control_dec.sv
// Combinational ALU control decoder: (ALUOp, funct) -> (4-bit ALU control, illegal flag).
// Undecodable combinations fall back to add so the ALU still sees a defined code.
module alu_control_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       illegal
);

  // Decode ALUOp class, then funct for R-type
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    unique case (alu_op)
      ALUOP_MEM:    alu_control = ALU_ADD;
      ALUOP_BRANCH: alu_control = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_NOR: alu_control = ALU_NOR;
          FUNCT_SLT: alu_control = ALU_SLT;
          default:   illegal     = 1'b1;
        endcase
      end
      default:      illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU control, selects operand B, and holds the ALU
// inputs behind a valid/ready handshake with flush and an issued-instruction counter.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned IMMW = 16,
  parameter int unsigned RW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  logic [3:0]    decCtrl;
  logic          decIllegal;
  logic [DW-1:0] operandB;
  logic          inReady;
  logic          load;
  logic          handoff;

  logic          validQ,   validD;
  logic [3:0]    ctrlQ,    ctrlD;
  logic [DW-1:0] data0Q,   data0D;
  logic [DW-1:0] data1Q,   data1D;
  logic [RW-1:0] rdQ,      rdD;
  logic          illegalQ, illegalD;
  logic [31:0]   issueQ,   issueD;

  alu_control_dec uDec (
    .alu_op      (bus.in_alu_op),
    .funct       (bus.in_funct),
    .alu_control (decCtrl),
    .illegal     (decIllegal)
  );

  // Operand B: register rt or sign-extended immediate
  always_comb begin
    operandB = bus.in_rt_data;
    if (bus.in_alu_src) begin
      operandB = {{(DW-IMMW){bus.in_imm[IMMW-1]}}, bus.in_imm};
    end
  end

  // Empty or draining this cycle means we can take a new instruction with no bubble
  assign inReady = !validQ || bus.out_ready;
  assign load    = bus.in_valid && inReady && !bus.flush;
  assign handoff = validQ && bus.out_ready && !bus.flush;

  // Next state: flush beats load, load beats drain; data regs only change on load
  always_comb begin
    validD   = validQ;
    ctrlD    = ctrlQ;
    data0D   = data0Q;
    data1D   = data1Q;
    rdD      = rdQ;
    illegalD = illegalQ;
    issueD   = handoff ? issueQ + 32'd1 : issueQ;
    if (bus.flush) begin
      validD = 1'b0;
    end else if (load) begin
      validD   = 1'b1;
      ctrlD    = decCtrl;
      data0D   = bus.in_rs_data;
      data1D   = operandB;
      rdD      = bus.in_rd;
      illegalD = decIllegal;
    end else if (bus.out_ready) begin
      validD = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      validQ   <= 1'b0;
      ctrlQ    <= ALU_ADD;
      data0Q   <= '0;
      data1Q   <= '0;
      rdQ      <= '0;
      illegalQ <= 1'b0;
      issueQ   <= '0;
    end else begin
      validQ   <= validD;
      ctrlQ    <= ctrlD;
      data0Q   <= data0D;
      data1Q   <= data1D;
      rdQ      <= rdD;
      illegalQ <= illegalD;
      issueQ   <= issueD;
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.out_valid   = validQ;
  assign bus.ALUControl  = ctrlQ;
  assign bus.DataIn0     = data0Q;
  assign bus.DataIn1     = data1Q;
  assign bus.out_rd      = rdQ;
  assign bus.out_illegal = illegalQ;
  assign bus.issue_count = issueQ;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table through a scoreboard, plus hold/flush/reset sequences.
module tb_id_ex_stage;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        src;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic running = 1'b0;
  int   nErr = 0;
  int   nChecks = 0;
  int   expIssue = 0;
  exp_t curExp;
  exp_t sb[$];
  vec_t vecs[12];

  id_ex_stage_if #(.DW(32), .IMMW(16), .RW(5)) bus ();

  id_ex_stage #(.DW(32), .IMMW(16), .RW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] funct, input logic src,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [15:0] imm, input logic [3:0] ctrl,
                              input logic [31:0] d1, input logic ill);
    vec_t v;
    v.op = op; v.funct = funct; v.src = src; v.rs = rs; v.rt = rt; v.imm = imm;
    v.ctrl = ctrl; v.d1 = d1; v.ill = ill;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic [4:0] rd, input logic valid);
    bus.in_valid   = valid;
    bus.in_alu_op  = v.op;
    bus.in_funct   = v.funct;
    bus.in_alu_src = v.src;
    bus.in_rs_data = v.rs;
    bus.in_rt_data = v.rt;
    bus.in_imm     = v.imm;
    bus.in_rd      = rd;
    curExp.ctrl = v.ctrl;
    curExp.d0   = v.rs;
    curExp.d1   = v.d1;
    curExp.rd   = rd;
    curExp.ill  = v.ill;
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ALUControl"}, 32'(bus.ALUControl), 32'h2);
    chk({tag, "_DataIn0"}, bus.DataIn0, 32'd0);
    chk({tag, "_DataIn1"}, bus.DataIn1, 32'd0);
    chk({tag, "_out_rd"}, 32'(bus.out_rd), 32'd0);
    chk({tag, "_out_illegal"}, 32'(bus.out_illegal), 32'd0);
    chk({tag, "_issue_count"}, bus.issue_count, 32'd0);
  endtask

  // Monitor then acceptor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (running && !reset) begin
      chk("issue_count", bus.issue_count, 32'(expIssue));
      if (bus.out_valid && bus.flush) begin
        if (sb.size() > 0) e = sb.pop_front();
      end else if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          nChecks++;
          nErr++;
          $display("FAIL sb_empty: got output with no expected entry at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("ALUControl", 32'(bus.ALUControl), 32'(e.ctrl));
          chk("DataIn0", bus.DataIn0, e.d0);
          chk("DataIn1", bus.DataIn1, e.d1);
          chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
          chk("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
        end
        expIssue++;
      end
      if (bus.in_valid && bus.in_ready && !bus.flush) sb.push_back(curExp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vA, vB, vC;
    vecs[0]  = mk(2'b10, 6'b100000, 1'b0, 32'd1, 32'd2, 16'h0, 4'b0010, 32'd2, 1'b0);
    vecs[1]  = mk(2'b01, 6'b000000, 1'b0, 32'd4, 32'd4, 16'h0, 4'b0110, 32'd4, 1'b0);
    vecs[2]  = mk(2'b10, 6'b101010, 1'b0, 32'hFFFFFFFF, 32'd3, 16'h0, 4'b0111, 32'd3, 1'b0);
    vecs[3]  = mk(2'b00, 6'b000000, 1'b1, 32'h10, 32'h55, 16'hFFFF, 4'b0010, 32'hFFFFFFFF,
                  1'b0);
    vecs[4]  = mk(2'b00, 6'b000000, 1'b1, 32'h20, 32'h66, 16'h7FFF, 4'b0010, 32'h00007FFF,
                  1'b0);
    vecs[5]  = mk(2'b10, 6'b100100, 1'b0, 32'hF0F0, 32'h0FF0, 16'h1234, 4'b0000, 32'h0FF0,
                  1'b0);
    vecs[6]  = mk(2'b10, 6'b100101, 1'b0, 32'hA, 32'h5, 16'h0, 4'b0001, 32'h5, 1'b0);
    vecs[7]  = mk(2'b10, 6'b100111, 1'b0, 32'h7, 32'h8, 16'h0, 4'b1100, 32'h8, 1'b0);
    vecs[8]  = mk(2'b10, 6'b100010, 1'b0, 32'h9, 32'h1, 16'h0, 4'b0110, 32'h1, 1'b0);
    vecs[9]  = mk(2'b11, 6'b100100, 1'b0, 32'h3, 32'h4, 16'h0, 4'b0010, 32'h4, 1'b1);
    vecs[10] = mk(2'b10, 6'b000000, 1'b0, 32'h5, 32'h6, 16'h0, 4'b0010, 32'h6, 1'b1);
    vecs[11] = mk(2'b01, 6'b000000, 1'b1, 32'hC, 32'hD, 16'h8000, 4'b0110, 32'hFFFF8000,
                  1'b0);
    vA = mk(2'b10, 6'b100101, 1'b0, 32'h11, 32'h22, 16'h0, 4'b0001, 32'h22, 1'b0);
    vB = mk(2'b01, 6'b000000, 1'b0, 32'h33, 32'h44, 16'h0, 4'b0110, 32'h44, 1'b0);
    vC = mk(2'b00, 6'b000000, 1'b1, 32'h77, 32'h0, 16'h0004, 4'b0010, 32'h4, 1'b0);

    reset = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(vA, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("por");
    chk("por_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    running = 1'b1;

    // Vector table, back to back with downstream always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i], 5'(i + 1), 1'b1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("table_drained", 32'(sb.size()), 32'd0);
    chk("table_issued", bus.issue_count, 32'd12);
    chk("table_out_valid", 32'(bus.out_valid), 32'd0);

    // Hold: A loads, B waits while downstream stalls
    bus.out_ready = 1'b0;
    drive(vA, 5'd3, 1'b1);
    @(posedge clk); #1;
    drive(vB, 5'd4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_ALUControl", 32'(bus.ALUControl), 32'h1);
      chk("hold_DataIn1", bus.DataIn1, 32'h22);
      chk("hold_out_rd", 32'(bus.out_rd), 32'd3);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_issued", bus.issue_count, 32'd14);
    chk("hold_drained", 32'(bus.out_valid), 32'd0);

    // Flush together with an incoming instruction on an empty stage
    @(posedge clk); #1;
    drive(vC, 5'd7, 1'b1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_in_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_issue", bus.issue_count, 32'd14);

    // Flush a valid stage while downstream is ready: no handoff counted
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(vC, 5'd8, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_full_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_full_issue", bus.issue_count, 32'd14);
    chk("flush_full_sb", 32'(sb.size()), 32'd0);

    // Reset mid-operation beats flush and load
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(vB, 5'd9, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    running = 1'b0;
    reset = 1'b1;
    bus.flush = 1'b1;
    drive(vA, 5'd10, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkReset("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    sb.delete();
    expIssue = 0;
    running = 1'b1;

    // One instruction after reset restarts the counter from zero
    drive(vecs[2], 5'd5, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_issue", bus.issue_count, 32'd1);
    chk("post_reset_sb", 32'(sb.size()), 32'd0);

    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
